// File: rtl/axi_lite_initiator.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_initiator
// Single-outstanding AXI-lite master behind a valid/ready command/response port.
// Rev    : 1.0
// ============================================================================
module axi_lite_initiator #(
  parameter int ADDRESS_WIDTH = 11,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     cmd_valid_i,
  input  logic                     cmd_write_i,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]              cmd_wdata_i,
  output logic                     cmd_ready_o,
  output logic                     rsp_valid_o,
  output logic [31:0]              rsp_rdata_o,
  output logic [1:0]               rsp_resp_o,
  output logic                     rsp_timeout_o,
  input  logic                     rsp_ready_i,
  output logic                     busy_o,
  output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [ADDRESS_WIDTH-1:0] m_axi_araddr,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [31:0]              m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                   state_q,       state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,        addr_d;
  logic [31:0]              wdata_q,       wdata_d;
  logic                     awvalid_q,     awvalid_d;
  logic                     wvalid_q,      wvalid_d;
  logic                     arvalid_q,     arvalid_d;
  logic                     aw_done_q,     aw_done_d;
  logic                     w_done_q,      w_done_d;
  logic [CW-1:0]            cnt_q,         cnt_d;
  logic [31:0]              rsp_rdata_q,   rsp_rdata_d;
  logic [1:0]               rsp_resp_q,    rsp_resp_d;
  logic                     rsp_timeout_q, rsp_timeout_d;
  logic                     w_expired;

  assign w_expired = (TIMEOUT > 0) && (cnt_q == CNT_MAX);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          if (cmd_write_i) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave only once both are done.
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_q && w_done_q) begin
          state_d = WR_RESP;
          cnt_d   = '0;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          state_d       = RSP;
          rsp_resp_d    = m_axi_bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
        end else if (w_expired) begin
          state_d       = RSP;
          rsp_resp_d    = 2'b10;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          cnt_d     = '0;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid) begin
          state_d       = RSP;
          rsp_resp_d    = m_axi_rresp;
          rsp_rdata_d   = m_axi_rdata;
          rsp_timeout_d = 1'b0;
        end else if (w_expired) begin
          state_d       = RSP;
          rsp_resp_d    = 2'b10;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cnt_q         <= '0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cnt_q         <= cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Handshake strobes are pure decodes of the registered state.
  assign cmd_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_rready  = (state_q == RD_RESP);
  assign rsp_valid_o   = (state_q == RSP);
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_resp_o    = rsp_resp_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_arvalid = arvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_initiator.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_lite_initiator
// Directed vector bench with a delay-programmable AXI-lite slave model.
// Rev    : 1.0
// ============================================================================
module tb_axi_lite_initiator;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [10:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  logic        cmd_ready_o, rsp_valid_o, rsp_timeout_o, busy_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic [10:0] m_axi_awaddr, m_axi_araddr;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_lite_initiator #(.ADDRESS_WIDTH(11), .TIMEOUT(8)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .cmd_valid_i(cmd_valid), .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata), .cmd_ready_o(cmd_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .rsp_timeout_o(rsp_timeout_o), .rsp_ready_i(rsp_ready), .busy_o(busy_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] data;
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0]  sresp;
    logic [31:0] srdata;
    int          hold;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_to;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL v%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  task automatic clear_slave();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int lat = -1, perr = 0, herr = 0, brise = 0, rrise = 0;
    logic pb = 1'b0, pr = 1'b0;
    @(negedge clk);
    chk(idx, "cmd_ready_idle", {31'd0, cmd_ready_o}, 1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.data;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) cmd_valid = 0;
      if (rsp_valid_o) begin
        lat = j;
        break;
      end
      // Each valid must be high exactly until its own handshake.
      if (m_axi_awvalid !== (v.wr && aw_hs == 0)) perr++;
      if (m_axi_wvalid !== (v.wr && w_hs == 0)) perr++;
      if (m_axi_arvalid !== (!v.wr && ar_hs == 0)) perr++;
      if (m_axi_awvalid && m_axi_awaddr !== v.addr) perr++;
      if (m_axi_wvalid && (m_axi_wdata !== v.data || m_axi_wstrb !== 4'hF)) perr++;
      if (m_axi_arvalid && m_axi_araddr !== v.addr) perr++;
      if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0) perr++;
      if (m_axi_bready && !pb) brise++;
      if (m_axi_rready && !pr) rrise++;
      pb = m_axi_bready;
      pr = m_axi_rready;
      bvalid = 0;
      if (aw_hs > 0 && w_hs > 0 && b_hs == 0) begin
        bvalid = (b_cnt >= v.b_dly);
        bresp  = v.sresp;
        b_cnt++;
        if (bvalid && m_axi_bready) b_hs++;
      end
      rvalid = 0;
      if (ar_hs > 0 && r_hs == 0) begin
        rvalid = (r_cnt >= v.r_dly);
        rresp  = v.sresp;
        rdata  = v.srdata;
        r_cnt++;
        if (rvalid && m_axi_rready) r_hs++;
      end
      awready = m_axi_awvalid && (aw_cnt >= v.aw_dly);
      if (m_axi_awvalid) aw_cnt++;
      if (m_axi_awvalid && awready) aw_hs++;
      wready = m_axi_wvalid && (w_cnt >= v.w_dly);
      if (m_axi_wvalid) w_cnt++;
      if (m_axi_wvalid && wready) w_hs++;
      arready = m_axi_arvalid && (ar_cnt >= v.ar_dly);
      if (m_axi_arvalid) ar_cnt++;
      if (m_axi_arvalid && arready) ar_hs++;
    end
    clear_slave();
    chk(idx, "latency", lat, v.exp_lat);
    if (lat < 0) begin
      reset_ni = 0;
      @(negedge clk);
      reset_ni = 1;
      return;
    end
    chk(idx, "rsp_rdata", rsp_rdata_o, v.exp_rdata);
    chk(idx, "rsp_resp", {30'd0, rsp_resp_o}, {30'd0, v.exp_resp});
    chk(idx, "rsp_timeout", {31'd0, rsp_timeout_o}, {31'd0, v.exp_to});
    chk(idx, "protocol_errs", perr, 0);
    chk(idx, "aw_w_ar_hs", {aw_hs[7:0], w_hs[7:0], ar_hs[7:0]},
        {8'(v.wr), 8'(v.wr), 8'(!v.wr)});
    chk(idx, "b_r_hs", {b_hs[15:0], r_hs[15:0]},
        {16'(v.wr && !v.exp_to), 16'(!v.wr && !v.exp_to)});
    chk(idx, "resp_phase_entries", {brise[15:0], rrise[15:0]}, {16'(v.wr), 16'(!v.wr)});
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== v.exp_rdata || rsp_resp_o !== v.exp_resp ||
          rsp_timeout_o !== v.exp_to || cmd_ready_o !== 1'b0) herr++;
    end
    chk(idx, "rsp_hold_stable", herr, 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk(idx, "idle_after", {29'd0, cmd_ready_o, busy_o, rsp_valid_o}, 32'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1);
  end

  initial begin
    //         wr  addr     data          aw w ar b   r   sresp  srdata        hold lat rdata         resp   to
    vecs[0] = '{1'b1, 11'h010, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        0, 3,  32'h0,        2'b00, 1'b0};
    vecs[1] = '{1'b0, 11'h005, 32'h0,        0, 0, 0, 0, 5, 2'b00, 32'h00000002, 1, 7,  32'h00000002, 2'b00, 1'b0};
    vecs[2] = '{1'b1, 11'h123, 32'h12345678, 0, 4, 0, 0, 0, 2'b01, 32'h0,        0, 7,  32'h0,        2'b01, 1'b0};
    vecs[3] = '{1'b1, 11'h7FF, 32'hA5A5A5A5, 4, 0, 0, 2, 0, 2'b11, 32'h0,        2, 8,  32'h0,        2'b11, 1'b0};
    vecs[4] = '{1'b0, 11'h3AB, 32'h0,        0, 0, 3, 0, 0, 2'b10, 32'hCAFEF00D, 10, 5, 32'hCAFEF00D, 2'b10, 1'b0};
    vecs[5] = '{1'b0, 11'h0AA, 32'h0,        0, 0, 0, 0, 99, 2'b00, 32'hDEADDEAD, 0, 9, 32'h0,        2'b10, 1'b1};
    vecs[6] = '{1'b0, 11'h0AB, 32'h0,        0, 0, 0, 0, 7, 2'b01, 32'h55AA55AA, 0, 9,  32'h55AA55AA, 2'b01, 1'b0};
    vecs[7] = '{1'b1, 11'h200, 32'h0F0F0F0F, 1, 2, 0, 99, 0, 2'b00, 32'h0,       0, 12, 32'h0,        2'b10, 1'b1};
    vecs[8] = '{1'b1, 11'h400, 32'h00000001, 2, 2, 0, 0, 0, 2'b00, 32'h0,        0, 5,  32'h0,        2'b00, 1'b0};
    vecs[9] = '{1'b0, 11'h001, 32'h0,        0, 0, 0, 0, 1, 2'b00, 32'hFFFFFFFF, 0, 3,  32'hFFFFFFFF, 2'b00, 1'b0};

    repeat (2) @(negedge clk);
    chk(0, "reset_flags", {25'd0, cmd_ready_o, busy_o, rsp_valid_o, m_axi_awvalid,
        m_axi_wvalid, m_axi_arvalid, m_axi_bready || m_axi_rready}, 32'b1000000);
    chk(0, "reset_wstrb", {28'd0, m_axi_wstrb}, 32'hF);
    chk(0, "reset_rsp", {rsp_rdata_o[29:0], rsp_resp_o}, 0);
    reset_ni = 1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Asynchronous reset while AW/W are stalled in the request phase.
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 11'h055; cmd_wdata = 32'h11112222;
    @(negedge clk);
    cmd_valid = 0;
    chk(20, "wr_req_valids", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'b11);
    @(negedge clk);
    #2 reset_ni = 0;
    #1;
    chk(20, "rst_mid_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
        rsp_valid_o, busy_o}, 0);
    chk(20, "rst_mid_ready_strb", {27'd0, cmd_ready_o, m_axi_wstrb}, 32'h1F);
    chk(20, "rst_mid_wdata", m_axi_wdata, 0);
    @(posedge clk);
    @(negedge clk);
    reset_ni = 1;
    @(negedge clk);
    chk(20, "post_rst_idle", {30'd0, cmd_ready_o, busy_o}, 32'b10);
    run_vec(21, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_initiator.md
AXI_LITE_INITIATOR -- requirements
Module: axi_lite_initiator

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 11, AXI-lite address width.
REQ-002 SHALL have parameter TIMEOUT, default 1024, response-wait limit in cycles; 0 disables the timeout.
REQ-003 SHALL have input clk_i, 1 bit, the single clock.
REQ-004 SHALL have input reset_ni, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have command inputs cmd_valid_i (1), cmd_write_i (1), cmd_addr_i (ADDRESS_WIDTH) and cmd_wdata_i (32).
REQ-006 SHALL have output cmd_ready_o, 1 bit, command accepted on cmd_valid_i && cmd_ready_o.
REQ-007 SHALL have response outputs rsp_valid_o (1), rsp_rdata_o (32), rsp_resp_o (2) and rsp_timeout_o (1), plus input rsp_ready_i (1).
REQ-008 SHALL have output busy_o, 1 bit, high whenever the state is not IDLE.
REQ-009 SHALL have AXI-lite master outputs m_axi_awaddr (ADDRESS_WIDTH), m_axi_awvalid, m_axi_wdata (32), m_axi_wstrb (4), m_axi_wvalid, m_axi_bready, m_axi_araddr (ADDRESS_WIDTH), m_axi_arvalid and m_axi_rready.
REQ-010 SHALL have AXI-lite master inputs m_axi_awready, m_axi_wready, m_axi_bresp (2), m_axi_bvalid, m_axi_arready, m_axi_rdata (32), m_axi_rresp (2), m_axi_rvalid.

Function
REQ-011 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-012 SHALL assert cmd_ready_o only in IDLE; on a command handshake, SHALL register address, data and direction and go to WR_REQ (write) or RD_REQ (read).
REQ-013 SHALL, on entering WR_REQ, assert m_axi_awvalid and m_axi_wvalid together; each drops the cycle after its own ready handshake, independently (AW before W, W before AW, or both in the same cycle).
REQ-014 SHALL move WR_REQ -> WR_RESP in the cycle after both AW and W have completed, and hold m_axi_bready high only in WR_RESP.
REQ-015 SHALL, on bvalid && bready, latch m_axi_bresp into rsp_resp_o, set rsp_rdata_o=0 and rsp_timeout_o=0, and go to RSP.
REQ-016 SHALL, in RD_REQ, hold m_axi_arvalid high until arready, then go to RD_RESP with m_axi_rready high only there.
REQ-017 SHALL, on rvalid && rready, latch m_axi_rdata and m_axi_rresp into rsp_rdata_o and rsp_resp_o, set rsp_timeout_o=0, and go to RSP.
REQ-018 SHALL hold rsp_valid_o high only in RSP, keep the response outputs stable until rsp_ready_i, then return to IDLE.
REQ-019 SHALL keep m_axi_wstrb at 4'hF, and keep the address and data outputs stable while the corresponding valid is high.
REQ-020 SHALL never deassert awvalid, wvalid or arvalid before their handshake; the request phases have no timeout.
REQ-021 SHALL, when TIMEOUT>0, clear a cycle counter on entry to WR_RESP or RD_RESP and increment it each cycle without a handshake.
REQ-022 SHALL, if the counter reaches TIMEOUT-1 without a handshake, go to RSP with rsp_resp_o=2'b10, rsp_rdata_o=0 and rsp_timeout_o=1; a handshake in that same cycle SHALL take priority.
REQ-023 SHALL, with a zero-wait slave (ready same cycle, response the following cycle), assert rsp_valid_o exactly 3 cycles after the command handshake.

Reset
REQ-024 SHALL, while reset_ni=0, force state IDLE and cmd_ready_o=1, with every other output at 0 except m_axi_wstrb=4'hF, asynchronously including mid-transaction.
REQ-025 SHALL resume normal operation on the first rising clk_i edge after reset_ni returns to 1.

Verification
REQ-026 Write addr 0x010, data 0xDEADBEEF, zero-wait slave, bresp=0 -> AW/W seen once with these values, wstrb=F; rsp_valid_o 3 cycles after accept, resp=0, timeout=0.
REQ-027 Read addr 0x005, slave returns 0x00000002 after 5-cycle delay -> rsp_rdata_o=0x00000002, resp=0; arvalid drops after one handshake.
REQ-028 Write with wready 4 cycles after awready, then the reverse order -> each valid drops only after its own handshake; a single WR_RESP entry.
REQ-029 TIMEOUT=8, read with rvalid never asserted -> rsp_valid_o with resp=2'b10 and timeout=1, 8 cycles after entering RD_RESP; next command accepted normally.
REQ-030 rsp_ready_i held low 10 cycles -> response stable, cmd_ready_o=0 throughout; reset_ni pulsed low during WR_REQ -> all valids 0 immediately, IDLE after release.
